agc_gain_controller: RTL
========================

AGC_GAIN_CONTROLLER -- requirements
Module: agc_gain_controller

Interface
REQ-001 SHALL have parameter GAIN_MAX, default 38, meaning highest legal gain index.
REQ-002 SHALL have parameter GAIN_INIT, default 38, meaning gain index loaded at reset.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16, meaning clocks ignored after each gain change.
REQ-004 SHALL have parameter WINDOW_LEN, default 64, meaning valid samples per measurement window.
REQ-005 SHALL have parameter LOCK_WINDOWS, default 4, meaning consecutive in-range windows before lock.
REQ-006 SHALL have ports, one per line:
 clk  input  1  single clock; all state on rising edge
 rst_n  input  1  reset, asynchronous, active-low
 enable  input  1  loop run; 0 freezes gain
 sample_valid  input  1  sample qualifier
 sample  input  8  signed two's-complement ADC sample
 thresh_hi  input  7  peak above this: reduce gain
 thresh_lo  input  7  peak below this: raise gain
 gain_array  output  6  gain index, 0..GAIN_MAX
 gain_update  output  1  one-cycle pulse when gain_array changes
 locked  output  1  loop settled in range

Function
REQ-007 SHALL implement FSM states IDLE, SETTLE, MEASURE, ADJUST.
REQ-008 IDLE: gain held; enable=1 -> SETTLE, settle counter loaded with SETTLE_CYCLES.
REQ-009 SETTLE: counter decrements every clock regardless of sample_valid; samples ignored; at count 1 -> MEASURE with peak=0, sample count=0.
REQ-010 MEASURE: each sample_valid cycle, magnitude=|sample|, -128 saturates to 127; peak=max(peak, magnitude); sample count increments.
REQ-011 MEASURE: cycle accepting the WINDOW_LEN-th valid sample -> ADJUST; that sample included in peak.
REQ-012 ADJUST lasts exactly one clock; decision uses final peak.
REQ-013 ADJUST, peak=127: gain decreases by 4, clamped at 0.
REQ-014 ADJUST, thresh_hi<peak<127: gain decreases by 1, clamped at 0.
REQ-015 ADJUST, peak<thresh_lo and no high condition: gain increases by 1, clamped at GAIN_MAX.
REQ-016 High condition SHALL take priority over low when thresh_lo>thresh_hi.
REQ-017 Gain changed -> SETTLE (counter reloaded), gain_update=1 for the following cycle only, lock counter cleared, locked=0.
REQ-018 Gain unchanged because thresh_lo<=peak<=thresh_hi -> MEASURE (no settle), lock counter increments, saturating at LOCK_WINDOWS.
REQ-019 Gain unchanged only because clamped at 0 or GAIN_MAX -> MEASURE, lock counter cleared, locked=0.
REQ-020 locked SHALL be 1 exactly when lock counter equals LOCK_WINDOWS.
REQ-021 gain_array SHALL be registered, updated on the ADJUST clock edge, and never exceed GAIN_MAX.
REQ-022 enable=0 in any state -> IDLE next clock; gain_array held; peak, counters and locked cleared; no gain_update; in-progress window discarded.
REQ-023 enable re-asserted -> SETTLE from current gain_array, not GAIN_INIT.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state IDLE, gain_array=GAIN_INIT, gain_update=0, locked=0, peak and all counters 0.
REQ-025 Release SHALL be synchronous to clk; first state change on the first edge with rst_n=1 and enable=1.
REQ-026 Reset assertion mid-window or mid-settle SHALL discard all progress.

Verification
REQ-027 Reset, enable=1, 16 idle clocks, 64 valid samples of +40, thresh 30/50 x4 windows -> gain stays 38, gain_update never 1, locked=1 after 4th ADJUST.
REQ-028 gain 38, samples alternating -128/+10 -> each window gain steps 38,34,30...; gain_update pulses once per change; locked=0.
REQ-029 gain 1, one window peak=127 -> gain 0 (clamped), then peak=100, thresh_hi 50 -> gain stays 0, no pulse, locked=0.
REQ-030 gain 38, peak=5, thresh_lo 20 -> gain stays 38, lock counter cleared, next state MEASURE without settle.
REQ-031 thresh_lo=60, thresh_hi=40, peak=50 -> gain decrements by 1 (high priority).
REQ-032 enable dropped after 30 samples of a window, re-raised 3 clocks later -> gain held, 16-clock settle, fresh 64-sample window; rst_n pulse mid-window -> gain_array=38 immediately without clock edge.

Source files
------------

// File: rtl/agc_gain_controller.sv
// agc_gain_controller: peak-detecting automatic gain control loop.
// The loop waits SETTLE_CYCLES clocks after each gain change. It then collects
// the peak magnitude over WINDOW_LEN valid samples and steps the gain index
// toward the thresh_lo..thresh_hi band.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             loop run; 0 returns to IDLE and freezes the gain
//   sample_valid       qualifies sample
//   sample [7:0]       signed ADC sample
//   thresh_hi [6:0]    peak above this lowers the gain
//   thresh_lo [6:0]    peak below this raises the gain
//   gain_array [5:0]   registered gain index, 0..GAIN_MAX
//   gain_update        one-cycle pulse alongside each new gain_array value
//   locked             LOCK_WINDOWS consecutive in-range windows seen
module agc_gain_controller #(
   parameter int unsigned GAIN_MAX      = 38,
   parameter int unsigned GAIN_INIT     = 38,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned WINDOW_LEN    = 64,
   parameter int unsigned LOCK_WINDOWS  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       sample_valid,
   input  logic [7:0] sample,
   input  logic [6:0] thresh_hi,
   input  logic [6:0] thresh_lo,
   output logic [5:0] gain_array,
   output logic       gain_update,
   output logic       locked
);

   localparam int unsigned GAIN_W = 6;
   localparam int unsigned MAG_W  = 7;
   localparam int unsigned SCNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned WCNT_W = $clog2(WINDOW_LEN + 1);
   localparam int unsigned LCNT_W = $clog2(LOCK_WINDOWS + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, ADJUST} state_t;

   state_t              state_q, state_d;
   logic [GAIN_W-1:0]   gain_q, gain_d;
   logic                gain_update_q, gain_update_d;
   logic                locked_q, locked_d;
   logic [MAG_W-1:0]    peak_q, peak_d;
   logic [SCNT_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic [WCNT_W-1:0]   win_cnt_q, win_cnt_d;
   logic [LCNT_W-1:0]   lock_cnt_q, lock_cnt_d;

   logic [MAG_W-1:0]    mag;
   logic                settle_done;
   logic                last_sample;
   logic                is_max, is_high, is_low, in_range;
   logic [GAIN_W-1:0]   gain_adj;
   logic                gain_changed;

   // Sample magnitude (-128 saturates to 127) and window/settle terminal counts.
   always_comb begin
      if (!sample[7])
         mag = sample[6:0];
      else if (sample == 8'h80)
         mag = 7'd127;
      else
         mag = MAG_W'(~sample + 8'd1);
      settle_done = (settle_cnt_q <= SCNT_W'(1));
      last_sample = (win_cnt_q == WCNT_W'(WINDOW_LEN - 1));
   end

   // Gain decision from the final window peak; high wins over low.
   always_comb begin
      is_max   = (peak_q == 7'd127);
      is_high  = is_max || (peak_q > thresh_hi);
      is_low   = !is_high && (peak_q < thresh_lo);
      in_range = !is_high && !is_low;
      gain_adj = gain_q;
      if (is_max)
         gain_adj = (gain_q >= 6'd4) ? gain_q - 6'd4 : 6'd0;
      else if (is_high)
         gain_adj = (gain_q != 6'd0) ? gain_q - 6'd1 : 6'd0;
      else if (is_low)
         gain_adj = (gain_q < GAIN_W'(GAIN_MAX)) ? gain_q + 6'd1 : gain_q;
      gain_changed = (gain_adj != gain_q);
   end

   // State register and datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         gain_q        <= GAIN_W'(GAIN_INIT);
         gain_update_q <= 1'b0;
         locked_q      <= 1'b0;
         peak_q        <= '0;
         settle_cnt_q  <= '0;
         win_cnt_q     <= '0;
         lock_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         gain_q        <= gain_d;
         gain_update_q <= gain_update_d;
         locked_q      <= locked_d;
         peak_q        <= peak_d;
         settle_cnt_q  <= settle_cnt_d;
         win_cnt_q     <= win_cnt_d;
         lock_cnt_q    <= lock_cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = SETTLE;
            SETTLE:  if (settle_done) state_d = MEASURE;
            MEASURE: if (sample_valid && last_sample) state_d = ADJUST;
            ADJUST:  state_d = gain_changed ? SETTLE : MEASURE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath and output next values.
   always_comb begin
      gain_d        = gain_q;
      gain_update_d = 1'b0;
      peak_d        = peak_q;
      settle_cnt_d  = settle_cnt_q;
      win_cnt_d     = win_cnt_q;
      lock_cnt_d    = lock_cnt_q;
      if (!enable) begin
         peak_d       = '0;
         settle_cnt_d = '0;
         win_cnt_d    = '0;
         lock_cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: settle_cnt_d = SCNT_W'(SETTLE_CYCLES);
            SETTLE: begin
               if (settle_done) begin
                  settle_cnt_d = '0;
                  peak_d       = '0;
                  win_cnt_d    = '0;
               end else begin
                  settle_cnt_d = settle_cnt_q - SCNT_W'(1);
               end
            end
            MEASURE: begin
               if (sample_valid) begin
                  if (mag > peak_q) peak_d = mag;
                  win_cnt_d = win_cnt_q + WCNT_W'(1);
               end
            end
            ADJUST: begin
               peak_d    = '0;
               win_cnt_d = '0;
               if (gain_changed) begin
                  gain_d        = gain_adj;
                  gain_update_d = 1'b1;
                  settle_cnt_d  = SCNT_W'(SETTLE_CYCLES);
                  lock_cnt_d    = '0;
               end else if (in_range) begin
                  if (lock_cnt_q < LCNT_W'(LOCK_WINDOWS))
                     lock_cnt_d = lock_cnt_q + LCNT_W'(1);
               end else begin
                  // Clamped at a gain limit: out of range, so not settling.
                  lock_cnt_d = '0;
               end
            end
            default: ;
         endcase
      end
      locked_d = (lock_cnt_d == LCNT_W'(LOCK_WINDOWS));
   end

   assign gain_array  = gain_q;
   assign gain_update = gain_update_q;
   assign locked      = locked_q;

endmodule
